proc_mc: RTL and testbench

PROC_MC -- requirements
Module: proc_mc

---
 rtl/proc_mc_pkg.sv | 46 ++++
 rtl/proc_mc_regs.sv | 32 +++
 rtl/proc_mc.sv | 213 +++++++++++++++++++++
 tb/tb_proc_mc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_mc_pkg.sv
// rtl/proc_mc_pkg.sv - opcodes, FSM states and instruction field offsets for proc_mc
package proc_mc_pkg;

  localparam int OPCODE_W  = 8;
  localparam int SEL_W     = 8;
  localparam int CHAN_W    = 3;
  localparam int REG_A_LSB = 4;
  localparam int REG_W_LSB = 0;

  typedef enum logic [7:0] {
    OP_NOP      = 8'h00,
    OP_PULSE    = 8'h01,
    OP_JUMP     = 8'h02,
    OP_JUMP_NZ  = 8'h03,
    OP_ADDI     = 8'h04,
    OP_QCLK_RST = 8'h05,
    OP_SYNC     = 8'h06,
    OP_DONE     = 8'h07
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    WAIT_TIME,
    WAIT_SYNC,
    DONE
  } state_e;

  // Fields are packed from the MSB down: opcode, imm, sel, pulse data.
  function automatic int op_lsb(input int cmd_w);
    return cmd_w - OPCODE_W;
  endfunction

  function automatic int imm_lsb(input int cmd_w, input int data_w);
    return op_lsb(cmd_w) - data_w;
  endfunction

  function automatic int sel_lsb(input int cmd_w, input int data_w);
    return imm_lsb(cmd_w, data_w) - SEL_W;
  endfunction

  function automatic int pdata_lsb(input int cmd_w, input int data_w, input int pulse_w);
    return sel_lsb(cmd_w, data_w) - pulse_w;
  endfunction

endpackage

// File: rtl/proc_mc_regs.sv
// rtl/proc_mc_regs.sv - proc_mc register file, two combinational reads and one synchronous write
module proc_mc_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/proc_mc.sv
// rtl/proc_mc.sv - timed pulse sequencer core with program memory, qclk timebase and sync barrier
// Define PROC_LATE_DETECT_EN to fire late pulses immediately and flag them on late_err.
module proc_mc
  import proc_mc_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int CMD_WIDTH          = 128,
  parameter int CMD_ADDR_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH     = 4,
  parameter int NUM_CHAN           = 2,
  parameter int PULSE_OUT_WIDTH    = 72,
  parameter int SYNC_BARRIER_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                write_prog_enable,
  input  logic [CMD_ADDR_WIDTH-1:0]           cmd_addr,
  input  logic [CMD_WIDTH-1:0]                cmd_data,
  input  logic                                sync_enable,
  output logic [NUM_CHAN*PULSE_OUT_WIDTH-1:0] cmd_out,
  output logic [NUM_CHAN-1:0]                 cstrobe_out,
  output logic [SYNC_BARRIER_WIDTH-1:0]       sync_barrier,
  output logic                                sync_barrier_en_out,
  output logic                                done_out,
  output logic                                late_err
);

  localparam int OP_LSB  = op_lsb(CMD_WIDTH);
  localparam int IMM_LSB = imm_lsb(CMD_WIDTH, DATA_WIDTH);
  localparam int SEL_LSB = sel_lsb(CMD_WIDTH, DATA_WIDTH);
  localparam int PD_LSB  = pdata_lsb(CMD_WIDTH, DATA_WIDTH, PULSE_OUT_WIDTH);

  logic [CMD_WIDTH-1:0]      prog [2**CMD_ADDR_WIDTH];
  logic [CMD_WIDTH-1:PD_LSB] ir;

  state_e                    state;
  logic [CMD_ADDR_WIDTH-1:0] ip;
  logic [CMD_ADDR_WIDTH-1:0] ip_inc;
  logic [DATA_WIDTH-1:0]     qclk;
  logic [DATA_WIDTH-1:0]     qclk_inc;

  logic [OPCODE_W-1:0]        op;
  logic [DATA_WIDTH-1:0]      imm;
  logic [SEL_W-1:0]           sel;
  logic [PULSE_OUT_WIDTH-1:0] pdata;
  logic [CHAN_W-1:0]          chan;
  logic [REG_ADDR_WIDTH-1:0]  reg_a;
  logic [REG_ADDR_WIDTH-1:0]  reg_w;
  logic [CMD_ADDR_WIDTH-1:0]  target;

  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;
  logic                  rf_we;
  logic [DATA_WIDTH-1:0] rf_wd;

  logic is_pulse;
  logic time_hit;
  logic late_fire;
  logic fire;

  assign op     = ir[OP_LSB +: OPCODE_W];
  assign imm    = ir[IMM_LSB +: DATA_WIDTH];
  assign sel    = ir[SEL_LSB +: SEL_W];
  assign pdata  = ir[PD_LSB +: PULSE_OUT_WIDTH];
  assign chan   = sel[CHAN_W-1:0];
  assign reg_a  = sel[REG_A_LSB +: REG_ADDR_WIDTH];
  assign reg_w  = sel[REG_W_LSB +: REG_ADDR_WIDTH];
  assign target = imm[CMD_ADDR_WIDTH-1:0];

  assign ip_inc   = ip + 1'b1;
  assign qclk_inc = qclk + 1'b1;

  always_ff @(posedge clk) begin
    if (write_prog_enable) begin
      prog[cmd_addr] <= cmd_data;
    end
  end

  // The instruction register doubles as the synchronous read stage of program memory.
  always_ff @(posedge clk) begin
    if (state == FETCH) begin
      ir <= prog[ip][CMD_WIDTH-1:PD_LSB];
    end
  end

  proc_mc_regs #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_regs (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (reg_a),
    .rd_data_a (rd_a),
    .rd_addr_b (reg_a),
    .rd_data_b (rd_b),
    .wr_en     (rf_we),
    .wr_addr   (reg_w),
    .wr_data   (rf_wd)
  );

  assign rf_we = (state == EXEC) && (op == OP_ADDI);
  assign rf_wd = rd_a + imm;

  // Match on the upcoming qclk so the strobe lands in the cycle where qclk equals imm.
  assign is_pulse = (op == OP_PULSE);
  assign time_hit = (qclk_inc == imm);
  assign fire     = is_pulse &&
                    (((state == EXEC) && (time_hit || late_fire)) ||
                     ((state == WAIT_TIME) && time_hit));

`ifdef PROC_LATE_DETECT_EN
  logic late_q;

  assign late_fire = (state == EXEC) && is_pulse && (imm < qclk);
  assign late_err  = late_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      late_q <= 1'b0;
    end else if (late_fire) begin
      late_q <= 1'b1;
    end
  end
`else
  assign late_fire = 1'b0;
  assign late_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= FETCH;
      ip                  <= '0;
      qclk                <= '0;
      cstrobe_out         <= '0;
      cmd_out             <= '0;
      sync_barrier        <= '0;
      sync_barrier_en_out <= 1'b0;
      done_out            <= 1'b0;
    end else begin
      qclk <= qclk_inc;
      for (int k = 0; k < NUM_CHAN; k++) begin
        cstrobe_out[k] <= fire && (chan == CHAN_W'(k));
        if (fire && (chan == CHAN_W'(k))) begin
          cmd_out[k*PULSE_OUT_WIDTH +: PULSE_OUT_WIDTH] <= pdata;
        end
      end

      case (state)
        FETCH: state <= EXEC;

        EXEC: begin
          case (op)
            OP_PULSE: begin
              if (fire) begin
                ip    <= ip_inc;
                state <= FETCH;
              end else begin
                state <= WAIT_TIME;
              end
            end
            OP_JUMP: begin
              ip    <= target;
              state <= FETCH;
            end
            OP_JUMP_NZ: begin
              ip    <= (rd_b != '0) ? target : ip_inc;
              state <= FETCH;
            end
            OP_QCLK_RST: begin
              qclk  <= '0;
              ip    <= ip_inc;
              state <= FETCH;
            end
            OP_SYNC: begin
              sync_barrier        <= imm[SYNC_BARRIER_WIDTH-1:0];
              sync_barrier_en_out <= 1'b1;
              state               <= WAIT_SYNC;
            end
            OP_DONE: begin
              done_out <= 1'b1;
              state    <= DONE;
            end
            default: begin
              ip    <= ip_inc;
              state <= FETCH;
            end
          endcase
        end

        WAIT_TIME: begin
          if (fire) begin
            ip    <= ip_inc;
            state <= FETCH;
          end
        end

        WAIT_SYNC: begin
          if (sync_enable) begin
            qclk                <= '0;
            sync_barrier_en_out <= 1'b0;
            ip                  <= ip_inc;
            state               <= FETCH;
          end
        end

        DONE: state <= DONE;

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_mc.sv
// tb/tb_proc_mc.sv - self-checking bench for proc_mc (honours PROC_LATE_DETECT_EN)
module tb_proc_mc;

  localparam int DW = 32;
  localparam int CW = 128;
  localparam int AW = 8;
  localparam int RW = 4;
  localparam int NC = 2;
  localparam int PW = 72;
  localparam int SW = 8;

  localparam logic [7:0] OPC_PULSE    = 8'h01;
  localparam logic [7:0] OPC_JUMP     = 8'h02;
  localparam logic [7:0] OPC_JUMP_NZ  = 8'h03;
  localparam logic [7:0] OPC_ADDI     = 8'h04;
  localparam logic [7:0] OPC_QCLK_RST = 8'h05;
  localparam logic [7:0] OPC_SYNC     = 8'h06;
  localparam logic [7:0] OPC_DONE     = 8'h07;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write_prog_enable = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [CW-1:0] cmd_data = '0;
  logic          sync_enable = 1'b0;
  logic [NC*PW-1:0] cmd_out;
  logic [NC-1:0]    cstrobe_out;
  logic [SW-1:0]    sync_barrier;
  logic             sync_barrier_en_out;
  logic             done_out;
  logic             late_err;

  int n_pass = 0;
  int n_total = 0;
  int t = 0;

  proc_mc #(
    .DATA_WIDTH(DW), .CMD_WIDTH(CW), .CMD_ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW),
    .NUM_CHAN(NC), .PULSE_OUT_WIDTH(PW), .SYNC_BARRIER_WIDTH(SW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .write_prog_enable   (write_prog_enable),
    .cmd_addr            (cmd_addr),
    .cmd_data            (cmd_data),
    .sync_enable         (sync_enable),
    .cmd_out             (cmd_out),
    .cstrobe_out         (cstrobe_out),
    .sync_barrier        (sync_barrier),
    .sync_barrier_en_out (sync_barrier_en_out),
    .done_out            (done_out),
    .late_err            (late_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [CW-1:0] mk(input logic [7:0] op, input logic [DW-1:0] imm,
                                       input logic [7:0] sel, input logic [PW-1:0] pd);
    return {op, imm, sel, pd, 8'h00};
  endfunction

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    step();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    t = 0;
  endtask

  task automatic load(input int a, input logic [CW-1:0] w);
    write_prog_enable = 1'b1;
    cmd_addr = AW'(a);
    cmd_data = w;
    step();
    write_prog_enable = 1'b0;
  endtask

  typedef struct {
    logic [DW-1:0] imm;
    logic [7:0]    chan;
    logic [PW-1:0] data;
    logic [NC-1:0] exp_strobe;
    int            exp_t;
  } pvec_t;

  pvec_t vt [5];
  logic [NC-1:0] es [512];
  logic [PW-1:0] ed [512];
  logic [7:0]    nops [4];

  initial begin
    int st_t, done_t, n_st, q, ft, n, dt, kind, ch;
    logic [NC-1:0]    st_v;
    logic [NC*PW-1:0] ecmd;
    logic [DW-1:0]    imm;
    logic [PW-1:0]    d;

    vt[0] = '{32'd20, 8'd1, 72'hAB,            2'b10, 20};
    vt[1] = '{32'd2,  8'd0, 72'h123,           2'b01, 2};
    vt[2] = '{32'd7,  8'd7, 72'hDEAD,          2'b00, -1};
    vt[3] = '{32'd33, 8'd0, {PW{1'b1}},        2'b01, 33};
    vt[4] = '{32'd5,  8'd2, 72'h4242,          2'b00, -1};
    nops = '{8'h00, 8'h08, 8'h5C, 8'hFF};

    @(negedge clk);
    hold_reset();
    check("rst_strobe", cstrobe_out, '0);
    check("rst_cmd", cmd_out, '0);
    check("rst_sync_en", sync_barrier_en_out, 1'b0);
    check("rst_barrier", sync_barrier, '0);
    check("rst_done", done_out, 1'b0);
    check("rst_late", late_err, 1'b0);

    // Single PULSE then DONE, from a vector table.
    for (int i = 0; i < 5; i++) begin
      hold_reset();
      load(0, mk(OPC_PULSE, vt[i].imm, vt[i].chan, vt[i].data));
      load(1, mk(OPC_DONE, '0, '0, '0));
      release_reset();
      st_t = -1; done_t = -1; n_st = 0; st_v = '0;
      for (int c = 0; c < 80; c++) begin
        if (cstrobe_out != '0) begin
          n_st++;
          if (st_t < 0) begin st_t = t; st_v = cstrobe_out; end
        end
        if (done_out && done_t < 0) done_t = t;
        step();
      end
      ecmd = '0;
      if (vt[i].chan < NC) ecmd[vt[i].chan*PW +: PW] = vt[i].data;
      check("tbl_strobe_val", st_v, vt[i].exp_strobe);
      check_int("tbl_strobe_t", st_t, vt[i].exp_t);
      check_int("tbl_strobe_cnt", n_st, (vt[i].exp_strobe != '0) ? 1 : 0);
      check_int("tbl_done_t", done_t, int'(vt[i].imm) + 2);
      check("tbl_done_held", done_out, 1'b1);
      check("tbl_cmd", cmd_out, ecmd);
    end

    // Counted loop: JUMP, ADDI, JUMP_NZ.
    hold_reset();
    load(0, mk(OPC_JUMP, 32'd8, 8'h00, '0));
    load(8, mk(OPC_ADDI, 32'd3, 8'h01, '0));
    load(9, mk(OPC_JUMP, 32'd1, 8'h00, '0));
    load(1, mk(OPC_QCLK_RST, '0, '0, '0));
    load(2, mk(OPC_PULSE, 32'd4, 8'd0, 72'h55));
    load(3, mk(OPC_ADDI, 32'hFFFF_FFFF, 8'h11, '0));
    load(4, mk(OPC_JUMP_NZ, 32'd1, 8'h10, '0));
    load(5, mk(OPC_DONE, '0, '0, '0));
    release_reset();
    n_st = 0; done_t = -1;
    for (int c = 0; c < 200 && done_t < 0; c++) begin
      if (cstrobe_out[0]) n_st++;
      if (done_out) done_t = t;
      step();
    end
    check_int("loop_count", n_st, 3);
    check("loop_done", done_out, 1'b1);
    check("loop_cmd0", cmd_out[PW-1:0], 72'h55);

    // SYNC barrier: early release ignored, real release zeroes qclk.
    hold_reset();
    load(0, mk(OPC_SYNC, 32'h305, '0, '0));
    load(1, mk(OPC_PULSE, 32'd3, 8'd1, 72'h77));
    load(2, mk(OPC_DONE, '0, '0, '0));
    release_reset();
    step();
    sync_enable = 1'b1;
    step();
    sync_enable = 1'b0;
    check("sync_en_early", sync_barrier_en_out, 1'b1);
    check("sync_id", sync_barrier, 8'd5);
    while (t < 10) step();
    check("sync_en_held", sync_barrier_en_out, 1'b1);
    sync_enable = 1'b1;
    step();
    sync_enable = 1'b0;
    check("sync_en_released", sync_barrier_en_out, 1'b0);
    st_t = -1; st_v = '0;
    for (int c = 0; c < 20; c++) begin
      if (cstrobe_out != '0 && st_t < 0) begin st_t = t; st_v = cstrobe_out; end
      step();
    end
    check_int("sync_pulse_t", st_t, 14);
    check("sync_pulse_val", st_v, 2'b10);
    check("sync_pulse_cmd", cmd_out[2*PW-1:PW], 72'h77);

    // Late pulse: imm already behind qclk at EXEC.
    hold_reset();
    for (int a = 0; a < 5; a++) load(a, mk(8'h00, '0, '0, '0));
    load(5, mk(OPC_PULSE, 32'd2, 8'd0, 72'h5A));
    load(6, mk(OPC_DONE, '0, '0, '0));
    release_reset();
    st_t = -1;
    for (int c = 0; c < 50; c++) begin
      if (cstrobe_out != '0 && st_t < 0) st_t = t;
      step();
    end
`ifdef PROC_LATE_DETECT_EN
    check_int("late_strobe_t", st_t, 12);
    check("late_err", late_err, 1'b1);
`else
    check_int("late_strobe_t", st_t, -1);
    check("late_err", late_err, 1'b0);
`endif

    // Reset while waiting for a pulse time.
    hold_reset();
    load(0, mk(OPC_PULSE, 32'd4, 8'd1, 72'hEE));
    load(1, mk(OPC_PULSE, 32'd40, 8'd0, 72'h99));
    load(2, mk(OPC_DONE, '0, '0, '0));
    release_reset();
    while (t < 10) step();
    check("mid_cmd_before", cmd_out[2*PW-1:PW], 72'hEE);
    reset = 1'b1;
    n_st = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (cstrobe_out != '0) n_st++;
    end
    check_int("mid_no_strobe", n_st, 0);
    check("mid_cmd_zero", cmd_out, '0);
    check("mid_done_zero", done_out, 1'b0);
    check("mid_sync_zero", sync_barrier_en_out, 1'b0);
    release_reset();
    st_t = -1; st_v = '0;
    for (int c = 0; c < 60; c++) begin
      if (cstrobe_out != '0 && st_t < 0) begin st_t = t; st_v = cstrobe_out; end
      step();
    end
    check_int("mid_restart_t", st_t, 4);
    check("mid_restart_val", st_v, 2'b10);

    // Random straight-line programs against a timing model.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 512; k++) es[k] = '0;
      hold_reset();
      q = 0; ft = 0;
      n = $urandom_range(8, 14);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 9);
        if (kind < 5) begin
          ch = $urandom_range(0, 3);
          d = {8'($urandom), $urandom, $urandom};
          imm = DW'(q + 2 + $urandom_range(0, 12));
          load(i, mk(OPC_PULSE, imm, 8'(ch), d));
          ft = ft + (int'(imm) - q);
          q = int'(imm);
          if (ch < NC) begin es[ft][ch] = 1'b1; ed[ft] = d; end
        end else if (kind == 5) begin
          load(i, mk(OPC_QCLK_RST, $urandom, '0, '0));
          ft += 2; q = 0;
        end else if (kind == 6) begin
          load(i, mk(OPC_ADDI, $urandom, 8'($urandom), '0));
          ft += 2; q += 2;
        end else begin
          load(i, mk(nops[$urandom_range(0, 3)], $urandom, 8'($urandom), {8'($urandom), $urandom, $urandom}));
          ft += 2; q += 2;
        end
      end
      load(n, mk(OPC_DONE, '0, '0, '0));
      dt = ft + 2;
      release_reset();
      ecmd = '0;
      while (t <= dt + 4) begin
        for (int c = 0; c < NC; c++) if (es[t][c]) ecmd[c*PW +: PW] = ed[t];
        check("rnd_strobe", cstrobe_out, es[t]);
        check("rnd_cmd", cmd_out, ecmd);
        check("rnd_done", done_out, t >= dt);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
